// File: rtl/grayscale_batch_scheduler.sv
// grayscale_batch_scheduler: packs RGB pixels into converter lanes, waits out the array latency, serializes grayscale results
module grayscale_batch_scheduler #(
  parameter int SIZE = 10,
  parameter int LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_r,
  input  logic [7:0]           in_g,
  input  logic [7:0]           in_b,
  input  logic                 in_last,
  output logic [SIZE-1:0][7:0] lane_r,
  output logic [SIZE-1:0][7:0] lane_g,
  output logic [SIZE-1:0][7:0] lane_b,
  input  logic [SIZE-1:0][7:0] lane_gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_gray,
  output logic                 out_last
);
  localparam int CW = $clog2(SIZE + 1);
  localparam int IW = $clog2(SIZE);
  localparam int WW = $clog2(LAT + 1);
  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, rd_q, rd_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [SIZE-1:0][7:0] r_q, r_d, g_q, g_d, b_q, b_d, res_q, res_d;
  logic batch_last_q, batch_last_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [7:0] out_gray_q, out_gray_d;
  logic acc, fire, close, final_beat;
  logic [IW-1:0] wr_idx, nx_idx;
  assign in_ready = !rst && state_q == FILL;
  assign acc = in_valid && in_ready;
  assign fire = out_valid_q && out_ready;
  assign close = count_q + CW'(1) == CW'(SIZE) || in_last;
  assign final_beat = rd_q == count_q - CW'(1);
  assign wr_idx = IW'(count_q);
  assign nx_idx = IW'(rd_q + CW'(1));
  assign lane_r = r_q;
  assign lane_g = g_q;
  assign lane_b = b_q;
  assign out_valid = out_valid_q;
  assign out_gray = out_gray_q;
  assign out_last = out_last_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d = rd_q;
    wait_d = wait_q;
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    res_d = res_q;
    batch_last_d = batch_last_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    out_gray_d = out_gray_q;
    case (state_q)
      FILL: if (acc) begin
        if (count_q == '0) begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
        r_d[wr_idx] = in_r;
        g_d[wr_idx] = in_g;
        b_d[wr_idx] = in_b;
        count_d = count_q + CW'(1);
        if (close) begin
          state_d = WAIT;
          batch_last_d = in_last;
          wait_d = WW'(LAT);
        end
      end
      WAIT: if (wait_q == '0) begin
        for (int i = 0; i < SIZE; i++) res_d[i] = (CW'(i) < count_q) ? lane_gray[i] : 8'd0;
        state_d = DRAIN;
        out_valid_d = 1'b1;
        out_gray_d = lane_gray[0];
        out_last_d = batch_last_q && count_q == CW'(1);
      end else begin
        wait_d = wait_q - WW'(1);
      end
      DRAIN: if (fire) begin
        if (final_beat) begin
          state_d = FILL;
          count_d = '0;
          rd_d = '0;
          batch_last_d = 1'b0;
          out_valid_d = 1'b0;
          out_last_d = 1'b0;
          out_gray_d = 8'd0;
        end else begin
          rd_d = rd_q + CW'(1);
          out_gray_d = res_q[nx_idx];
          out_last_d = batch_last_q && rd_q + CW'(2) == count_q;
        end
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      rd_q <= '0;
      wait_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      res_q <= '0;
      batch_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_gray_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q <= rd_d;
      wait_q <= wait_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      res_q <= res_d;
      batch_last_q <= batch_last_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      out_gray_q <= out_gray_d;
    end
  end
endmodule
